// File: rtl/ysyx_23060203_core_seq.sv
// Multi-cycle sequencer for the NPC core: owns pc/inst and steps FETCH..WB.
// Gates rf write and IFU/LSU handshakes, and keeps cycle/instret/halt/err status.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_FETCH  | ifu_req high; latch ifu_rdata into inst on ifu_valid
// S_DECODE | one cycle for the combinational IDU to settle on inst
// S_EXEC   | sample is_mem/is_ebreak and pick MEM or WB
// S_MEM    | lsu_req high until lsu_done
// S_WB     | rf_we gated by rd_wen, pc <= next_pc, instruction retires
// S_HALT   | absorbing until reset; everything frozen
module ysyx_23060203_core_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [15:0] TIMEOUT  = 16'd1024,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req,
    input  logic             ifu_valid,
    input  logic [31:0]      ifu_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      inst,
    input  logic             is_mem,
    input  logic             is_ebreak,
    input  logic             rd_wen,
    input  logic [31:0]      next_pc,
    output logic             lsu_req,
    input  logic             lsu_done,
    output logic             rf_we,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] wait_nxt;
    logic        ebreak_q;
    logic        timeout_hit;
    logic        err_set;

    always_comb begin
        state_nxt   = state;
        wait_nxt    = 16'd0;
        err_set     = 1'b0;
        timeout_hit = (wait_cnt == (TIMEOUT - 16'd1));
        ifu_req     = (state == S_FETCH);
        lsu_req     = (state == S_MEM);
        rf_we       = (state == S_WB) && rd_wen;

        case (state)
            S_FETCH: begin
                // A response in the last allowed cycle still wins over the timeout.
                if (ifu_valid) begin
                    state_nxt = S_DECODE;
                end else if (timeout_hit) begin
                    state_nxt = S_HALT;
                    err_set   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 16'd1;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (is_ebreak) begin
                    state_nxt = S_WB;
                end else if (is_mem) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_done) begin
                    state_nxt = S_WB;
                end else if (timeout_hit) begin
                    state_nxt = S_HALT;
                    err_set   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 16'd1;
                end
            end
            S_WB:    state_nxt = ebreak_q ? S_HALT : S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            wait_cnt    <= 16'd0;
            pc          <= RESET_PC;
            inst        <= 32'd0;
            ebreak_q    <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == S_FETCH && ifu_valid) begin
                inst <= ifu_rdata;
            end
            if (state == S_EXEC) begin
                ebreak_q <= is_ebreak;
            end
            if (state == S_WB) begin
                pc          <= next_pc;
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
            if (state != S_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (state_nxt == S_HALT) begin
                halted <= 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_core_seq.sv
// Self-checking bench for ysyx_23060203_core_seq: per-instruction transaction
// model (pc, inst, counters, expected phase lengths) compared cycle by cycle.
module tb_ysyx_23060203_core_seq;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [15:0] TIMEOUT  = 16'd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req;
    logic        ifu_valid;
    logic [31:0] ifu_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_mem;
    logic        is_ebreak;
    logic        rd_wen;
    logic [31:0] next_pc;
    logic        lsu_req;
    logic        lsu_done;
    logic        rf_we;
    logic        halted;
    logic        err;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_cycle;
    logic [31:0] m_instret;
    bit          m_halted;

    ysyx_23060203_core_seq #(
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifu_req     (ifu_req),
        .ifu_valid   (ifu_valid),
        .ifu_rdata   (ifu_rdata),
        .pc          (pc),
        .inst        (inst),
        .is_mem      (is_mem),
        .is_ebreak   (is_ebreak),
        .rd_wen      (rd_wen),
        .next_pc     (next_pc),
        .lsu_req     (lsu_req),
        .lsu_done    (lsu_done),
        .rf_we       (rf_we),
        .halted      (halted),
        .err         (err),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; the model counts every cycle spent outside HALT.
    task automatic step();
        @(posedge clk);
        #1;
        if (!m_halted) m_cycle++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_pc      = RESET_PC;
        m_inst    = 32'd0;
        m_cycle   = 32'd0;
        m_instret = 32'd0;
        m_halted  = 1'b0;
    endtask

    // Decode-side inputs are don't-care outside their sampling states.
    task automatic scramble();
        is_mem    = 1'($urandom);
        is_ebreak = 1'($urandom);
        rd_wen    = 1'($urandom);
        next_pc   = $urandom;
        lsu_done  = 1'($urandom);
    endtask

    // One instruction: fw idle fetch cycles, optional mem access with mw idle cycles.
    task automatic run_instr(input int fw, input bit mem, input int mw, input bit wen,
                             input bit ebrk, input logic [31:0] rdata,
                             input logic [31:0] npc);
        for (int k = 0; k <= fw; k++) begin
            scramble();
            ifu_valid = (k == fw);
            ifu_rdata = (k == fw) ? rdata : $urandom;
            @(negedge clk);
            checks++;
            if ({ifu_req, lsu_req, rf_we, halted, err} !== 5'b10000 || pc !== m_pc ||
                cycle_cnt !== m_cycle || instret_cnt !== m_instret) begin
                failures++;
                $display("FAIL fetch[%0d]: ctl=%b pc=%h cyc=%0d ret=%0d, want ctl=10000 pc=%h cyc=%0d ret=%0d",
                         k, {ifu_req, lsu_req, rf_we, halted, err}, pc, cycle_cnt, instret_cnt,
                         m_pc, m_cycle, m_instret);
            end
            step();
        end
        m_inst = rdata;

        scramble();
        ifu_valid = 1'($urandom);
        ifu_rdata = $urandom;
        @(negedge clk);
        checks++;
        if ({ifu_req, lsu_req, rf_we, halted, err} !== 5'b00000 || inst !== m_inst ||
            cycle_cnt !== m_cycle) begin
            failures++;
            $display("FAIL decode: ctl=%b inst=%h cyc=%0d, want ctl=00000 inst=%h cyc=%0d",
                     {ifu_req, lsu_req, rf_we, halted, err}, inst, cycle_cnt, m_inst, m_cycle);
        end
        step();

        scramble();
        is_mem    = mem;
        is_ebreak = ebrk;
        ifu_valid = 1'b1;
        ifu_rdata = ~rdata;
        @(negedge clk);
        checks++;
        if ({ifu_req, lsu_req, rf_we, halted, err} !== 5'b00000 || inst !== m_inst ||
            cycle_cnt !== m_cycle) begin
            failures++;
            $display("FAIL exec: ctl=%b inst=%h cyc=%0d, want ctl=00000 inst=%h cyc=%0d",
                     {ifu_req, lsu_req, rf_we, halted, err}, inst, cycle_cnt, m_inst, m_cycle);
        end
        step();

        if (mem && !ebrk) begin
            for (int k = 0; k <= mw; k++) begin
                scramble();
                lsu_done  = (k == mw);
                ifu_valid = 1'($urandom);
                ifu_rdata = $urandom;
                @(negedge clk);
                checks++;
                if ({ifu_req, lsu_req, rf_we, halted, err} !== 5'b01000 || inst !== m_inst ||
                    cycle_cnt !== m_cycle) begin
                    failures++;
                    $display("FAIL mem[%0d]: ctl=%b inst=%h cyc=%0d, want ctl=01000 inst=%h cyc=%0d",
                             k, {ifu_req, lsu_req, rf_we, halted, err}, inst, cycle_cnt,
                             m_inst, m_cycle);
                end
                step();
            end
        end

        scramble();
        rd_wen    = wen;
        next_pc   = npc;
        ifu_valid = 1'($urandom);
        ifu_rdata = $urandom;
        @(negedge clk);
        checks++;
        if ({ifu_req, lsu_req, rf_we, halted, err} !== {2'b00, wen, 2'b00} || pc !== m_pc ||
            inst !== m_inst || cycle_cnt !== m_cycle || instret_cnt !== m_instret) begin
            failures++;
            $display("FAIL wb: ctl=%b pc=%h inst=%h cyc=%0d ret=%0d, want ctl=%b pc=%h inst=%h cyc=%0d ret=%0d",
                     {ifu_req, lsu_req, rf_we, halted, err}, pc, inst, cycle_cnt, instret_cnt,
                     {2'b00, wen, 2'b00}, m_pc, m_inst, m_cycle, m_instret);
        end
        step();
        m_pc = npc;
        m_instret++;
        if (ebrk) m_halted = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({ifu_req, lsu_req, rf_we, halted, err} !== 5'b10000 || pc !== RESET_PC ||
            inst !== 32'd0 || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset: ctl=%b pc=%h inst=%h cyc=%0d ret=%0d, want ctl=10000 pc=%h inst=0 cyc=0 ret=0",
                     {ifu_req, lsu_req, rf_we, halted, err}, pc, inst, cycle_cnt, instret_cnt,
                     RESET_PC);
        end
        do_reset();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            run_instr(0, 1'b0, 0, 1'b1, 1'b0, 32'h0010_0093 + 32'(i), m_pc + 32'd4);
        end
        checks++;
        if (m_pc !== RESET_PC + 32'd12 || m_cycle !== 32'd12) begin
            failures++;
            $display("FAIL basic_model: pc=%h cyc=%0d, want pc=%h cyc=12", m_pc, m_cycle,
                     RESET_PC + 32'd12);
        end
    endtask

    task automatic test_fetch_wait();
        run_instr(3, 1'b0, 0, 1'b1, 1'b0, 32'hdead_beef, m_pc + 32'd4);
    endtask

    task automatic test_load();
        run_instr(0, 1'b1, 2, 1'b1, 1'b0, 32'h0000_2103, m_pc + 32'd4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_instr(int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 5)),
                      1'($urandom), 1'b0, $urandom,
                      ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4);
        end
    endtask

    task automatic test_ebreak();
        // is_mem also high: ebreak must take priority and skip MEM.
        run_instr(1, 1'b1, 0, 1'b0, 1'b1, 32'h0010_0073, m_pc + 32'd4);
        for (int i = 0; i < 100; i++) begin
            scramble();
            ifu_valid = 1'($urandom);
            ifu_rdata = $urandom;
            rd_wen    = 1'b1;
            lsu_done  = 1'b1;
            @(negedge clk);
            checks++;
            if ({ifu_req, lsu_req, rf_we, halted, err} !== 5'b00010 || pc !== m_pc ||
                inst !== m_inst || cycle_cnt !== m_cycle || instret_cnt !== m_instret) begin
                failures++;
                $display("FAIL halt[%0d]: ctl=%b pc=%h inst=%h cyc=%0d ret=%0d, want ctl=00010 pc=%h inst=%h cyc=%0d ret=%0d",
                         i, {ifu_req, lsu_req, rf_we, halted, err}, pc, inst, cycle_cnt,
                         instret_cnt, m_pc, m_inst, m_cycle, m_instret);
            end
            step();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            scramble();
            ifu_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({ifu_req, halted, err} !== 3'b100) begin
                failures++;
                $display("FAIL timeout_wait[%0d]: req/halt/err=%b, want 100", k,
                         {ifu_req, halted, err});
            end
            step();
        end
        m_halted = 1'b1;
        for (int k = 0; k < 3; k++) begin
            scramble();
            ifu_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({ifu_req, lsu_req, rf_we, halted, err} !== 5'b00011 || cycle_cnt !== m_cycle ||
                pc !== RESET_PC || instret_cnt !== 32'd0) begin
                failures++;
                $display("FAIL timeout_halt: ctl=%b cyc=%0d pc=%h ret=%0d, want ctl=00011 cyc=%0d pc=%h ret=0",
                         {ifu_req, lsu_req, rf_we, halted, err}, cycle_cnt, pc, instret_cnt,
                         m_cycle, RESET_PC);
            end
            step();
        end
        // Response in the last permitted cycle must not raise err.
        do_reset();
        run_instr(int'(TIMEOUT) - 1, 1'b0, 0, 1'b1, 1'b0, 32'h1234_5678, 32'h8000_0100);
        run_instr(0, 1'b1, int'(TIMEOUT) - 1, 1'b0, 1'b0, 32'h0000_a023, 32'h8000_0104);
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        run_instr(0, 1'b0, 0, 1'b1, 1'b0, 32'h0000_0013, 32'h8000_0040);
        run_instr(0, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0013, 32'h8000_0044);
        scramble();
        ifu_valid = 1'b1;
        ifu_rdata = 32'h0000_2083;
        step();
        scramble();
        step();
        scramble();
        is_mem    = 1'b1;
        is_ebreak = 1'b0;
        step();
        scramble();
        lsu_done = 1'b0;
        step();
        lsu_done = 1'b0;
        do_reset();
        @(negedge clk);
        checks++;
        if ({ifu_req, lsu_req, rf_we, halted, err} !== 5'b10000 || pc !== RESET_PC ||
            inst !== 32'd0 || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_mem: ctl=%b pc=%h inst=%h cyc=%0d ret=%0d, want ctl=10000 pc=%h inst=0 cyc=0 ret=0",
                     {ifu_req, lsu_req, rf_we, halted, err}, pc, inst, cycle_cnt, instret_cnt,
                     RESET_PC);
        end
        do_reset();
        run_instr(0, 1'b0, 0, 1'b1, 1'b0, 32'h0000_0093, RESET_PC + 32'd4);
    endtask

    initial begin
        rst_n     = 1'b0;
        ifu_valid = 1'b0;
        ifu_rdata = 32'd0;
        is_mem    = 1'b0;
        is_ebreak = 1'b0;
        rd_wen    = 1'b0;
        next_pc   = 32'd0;
        lsu_done  = 1'b0;
        m_pc      = RESET_PC;
        m_inst    = 32'd0;
        m_cycle   = 32'd0;
        m_instret = 32'd0;
        m_halted  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        test_reset();
        test_basic();
        test_fetch_wait();
        test_load();
        test_random();
        test_ebreak();
        test_timeout();
        test_reset_mid_mem();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
